// File: rtl/rs_bank.sv
// Multi-entry reservation station: holds dispatched instructions, wakes operands from
// the CDB ports and issues the oldest fully-ready entry through a valid/ready handshake.
module rs_bank #(
    parameter int NUM_ENTRIES = 8,
    parameter int CDB_PORTS   = 2,
    parameter int TAG_W       = 5,
    parameter int XLEN        = 32,
    parameter int PAYLOAD_W   = 64
) (
    input  logic                           i_clock,
    input  logic                           i_reset_n,
    input  logic                           i_flush,

    input  logic                           i_disp_valid,
    output logic                           o_disp_ready,
    input  logic                           i_disp_rs1_ready,
    input  logic                           i_disp_rs2_ready,
    input  logic [TAG_W-1:0]               i_disp_rs1_tag,
    input  logic [TAG_W-1:0]               i_disp_rs2_tag,
    input  logic [XLEN-1:0]                i_disp_rs1_value,
    input  logic [XLEN-1:0]                i_disp_rs2_value,
    input  logic [TAG_W-1:0]               i_disp_dest_tag,
    input  logic [PAYLOAD_W-1:0]           i_disp_payload,

    input  logic [CDB_PORTS-1:0]           i_cdb_valid,
    input  logic [CDB_PORTS*TAG_W-1:0]     i_cdb_tag,
    input  logic [CDB_PORTS*XLEN-1:0]      i_cdb_value,

    output logic                           o_issue_valid,
    input  logic                           i_issue_ready,
    output logic [XLEN-1:0]                o_issue_rs1_value,
    output logic [XLEN-1:0]                o_issue_rs2_value,
    output logic [TAG_W-1:0]               o_issue_dest_tag,
    output logic [PAYLOAD_W-1:0]           o_issue_payload,

    output logic [$clog2(NUM_ENTRIES):0]   o_free_count
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int CNT_W = IDX_W + 1;

    logic [NUM_ENTRIES-1:0] r_busy;
    logic [NUM_ENTRIES-1:0] r_rs1_rdy;
    logic [NUM_ENTRIES-1:0] r_rs2_rdy;
    logic [TAG_W-1:0]       r_rs1_tag  [NUM_ENTRIES];
    logic [TAG_W-1:0]       r_rs2_tag  [NUM_ENTRIES];
    logic [XLEN-1:0]        r_rs1_val  [NUM_ENTRIES];
    logic [XLEN-1:0]        r_rs2_val  [NUM_ENTRIES];
    logic [TAG_W-1:0]       r_dest     [NUM_ENTRIES];
    logic [PAYLOAD_W-1:0]   r_payload  [NUM_ENTRIES];
    // r_older[i][j] set means entry j was dispatched before entry i
    logic [NUM_ENTRIES-1:0] r_older    [NUM_ENTRIES];

    logic [NUM_ENTRIES-1:0] w_hit1;
    logic [NUM_ENTRIES-1:0] w_hit2;
    logic [XLEN-1:0]        w_cval1    [NUM_ENTRIES];
    logic [XLEN-1:0]        w_cval2    [NUM_ENTRIES];
    logic                   w_dhit1;
    logic                   w_dhit2;
    logic [XLEN-1:0]        w_dval1;
    logic [XLEN-1:0]        w_dval2;

    logic [NUM_ENTRIES-1:0] w_cand;
    logic [NUM_ENTRIES-1:0] w_oldest;
    logic                   w_any;
    logic [IDX_W-1:0]       w_sel;
    logic [IDX_W-1:0]       w_free;
    logic [CNT_W-1:0]       w_busy_cnt;
    logic                   w_disp_fire;
    logic                   w_issue_fire;

    // CDB match: ports scanned high to low so the lowest matching port wins; tag 0 never matches
    always_comb begin
        w_dhit1 = 1'b0;
        w_dhit2 = 1'b0;
        w_dval1 = '0;
        w_dval2 = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_hit1[i]  = 1'b0;
            w_hit2[i]  = 1'b0;
            w_cval1[i] = '0;
            w_cval2[i] = '0;
        end
        for (int k = CDB_PORTS - 1; k >= 0; k--) begin
            if (i_cdb_valid[k]) begin
                for (int i = 0; i < NUM_ENTRIES; i++) begin
                    if (r_rs1_tag[i] != '0 && r_rs1_tag[i] == i_cdb_tag[k*TAG_W +: TAG_W]) begin
                        w_hit1[i]  = 1'b1;
                        w_cval1[i] = i_cdb_value[k*XLEN +: XLEN];
                    end
                    if (r_rs2_tag[i] != '0 && r_rs2_tag[i] == i_cdb_tag[k*TAG_W +: TAG_W]) begin
                        w_hit2[i]  = 1'b1;
                        w_cval2[i] = i_cdb_value[k*XLEN +: XLEN];
                    end
                end
                if (i_disp_rs1_tag != '0 && i_disp_rs1_tag == i_cdb_tag[k*TAG_W +: TAG_W]) begin
                    w_dhit1 = 1'b1;
                    w_dval1 = i_cdb_value[k*XLEN +: XLEN];
                end
                if (i_disp_rs2_tag != '0 && i_disp_rs2_tag == i_cdb_tag[k*TAG_W +: TAG_W]) begin
                    w_dhit2 = 1'b1;
                    w_dval2 = i_cdb_value[k*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        w_cand     = r_busy & r_rs1_rdy & r_rs2_rdy;
        w_any      = |w_cand;
        w_sel      = '0;
        w_free     = '0;
        w_busy_cnt = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_oldest[i] = w_cand[i] && ((r_older[i] & w_cand) == '0);
            w_busy_cnt  = w_busy_cnt + CNT_W'(r_busy[i]);
        end
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (w_oldest[i]) w_sel  = IDX_W'(i);
            if (!r_busy[i])  w_free = IDX_W'(i);
        end
    end

    always_comb begin
        o_issue_rs1_value = '0;
        o_issue_rs2_value = '0;
        o_issue_dest_tag  = '0;
        o_issue_payload   = '0;
        if (w_any) begin
            o_issue_rs1_value = r_rs1_val[w_sel];
            o_issue_rs2_value = r_rs2_val[w_sel];
            o_issue_dest_tag  = r_dest[w_sel];
            o_issue_payload   = r_payload[w_sel];
        end
    end

    assign o_issue_valid = w_any && !i_flush;
    assign o_disp_ready  = ~&r_busy;
    assign o_free_count  = CNT_W'(NUM_ENTRIES) - w_busy_cnt;
    assign w_disp_fire   = i_disp_valid && o_disp_ready && !i_flush;
    assign w_issue_fire  = o_issue_valid && i_issue_ready;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_busy    <= '0;
            r_rs1_rdy <= '0;
            r_rs2_rdy <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_rs1_tag[i] <= '0;
                r_rs2_tag[i] <= '0;
                r_rs1_val[i] <= '0;
                r_rs2_val[i] <= '0;
                r_dest[i]    <= '0;
                r_payload[i] <= '0;
                r_older[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (r_busy[i] && !r_rs1_rdy[i] && w_hit1[i]) begin
                    r_rs1_rdy[i] <= 1'b1;
                    r_rs1_val[i] <= w_cval1[i];
                end
                if (r_busy[i] && !r_rs2_rdy[i] && w_hit2[i]) begin
                    r_rs2_rdy[i] <= 1'b1;
                    r_rs2_val[i] <= w_cval2[i];
                end
            end
            if (w_issue_fire) r_busy[w_sel] <= 1'b0;
            if (w_disp_fire) begin
                r_busy[w_free]    <= 1'b1;
                r_rs1_rdy[w_free] <= i_disp_rs1_ready || w_dhit1;
                r_rs2_rdy[w_free] <= i_disp_rs2_ready || w_dhit2;
                r_rs1_tag[w_free] <= i_disp_rs1_tag;
                r_rs2_tag[w_free] <= i_disp_rs2_tag;
                r_rs1_val[w_free] <= i_disp_rs1_ready ? i_disp_rs1_value : w_dval1;
                r_rs2_val[w_free] <= i_disp_rs2_ready ? i_disp_rs2_value : w_dval2;
                r_dest[w_free]    <= i_disp_dest_tag;
                r_payload[w_free] <= i_disp_payload;
                // a reused slot must stop looking older to everyone else
                for (int j = 0; j < NUM_ENTRIES; j++) begin
                    r_older[j][w_free] <= 1'b0;
                end
                r_older[w_free] <= r_busy;
            end
            if (i_flush) r_busy <= '0;
        end
    end

endmodule

// File: tb/tb_rs_bank.sv
// Directed bench for rs_bank: dispatch, CDB wakeup, age ordering, full bank, flush and reset.
module tb_rs_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        disp_valid;
    logic        disp_ready;
    logic        rs1_rdy, rs2_rdy;
    logic [4:0]  rs1_tag, rs2_tag;
    logic [31:0] rs1_val, rs2_val;
    logic [4:0]  dest;
    logic [63:0] payload;
    logic [1:0]  cdb_valid;
    logic [9:0]  cdb_tag;
    logic [63:0] cdb_value;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] iss_rs1, iss_rs2;
    logic [4:0]  iss_dest;
    logic [63:0] iss_payload;
    logic [3:0]  free_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rs_bank dut (
        .i_clock           (clk),
        .i_reset_n         (rst_n),
        .i_flush           (flush),
        .i_disp_valid      (disp_valid),
        .o_disp_ready      (disp_ready),
        .i_disp_rs1_ready  (rs1_rdy),
        .i_disp_rs2_ready  (rs2_rdy),
        .i_disp_rs1_tag    (rs1_tag),
        .i_disp_rs2_tag    (rs2_tag),
        .i_disp_rs1_value  (rs1_val),
        .i_disp_rs2_value  (rs2_val),
        .i_disp_dest_tag   (dest),
        .i_disp_payload    (payload),
        .i_cdb_valid       (cdb_valid),
        .i_cdb_tag         (cdb_tag),
        .i_cdb_value       (cdb_value),
        .o_issue_valid     (issue_valid),
        .i_issue_ready     (issue_ready),
        .o_issue_rs1_value (iss_rs1),
        .o_issue_rs2_value (iss_rs2),
        .o_issue_dest_tag  (iss_dest),
        .o_issue_payload   (iss_payload),
        .o_free_count      (free_count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic r1, input logic [4:0] t1, input logic [31:0] v1,
                        input logic r2, input logic [4:0] t2, input logic [31:0] v2,
                        input logic [4:0] d);
        disp_valid = 1'b1;
        rs1_rdy = r1; rs1_tag = t1; rs1_val = v1;
        rs2_rdy = r2; rs2_tag = t2; rs2_val = v2;
        dest    = d;
        payload = {32'hC0DE_0000, 27'd0, d};
    endtask

    task automatic cdb(input int p, input logic [4:0] t, input logic [31:0] v);
        cdb_valid[p]         = 1'b1;
        cdb_tag[p*5 +: 5]    = t;
        cdb_value[p*32 +: 32] = v;
    endtask

    task automatic quiet();
        disp_valid = 1'b0;
        cdb_valid  = '0;
        cdb_tag    = '0;
        cdb_value  = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] drain_exp [8];
        rst_n = 1'b0; flush = 1'b0; issue_ready = 1'b0;
        rs1_rdy = 0; rs2_rdy = 0; rs1_tag = 0; rs2_tag = 0; rs1_val = 0; rs2_val = 0;
        dest = 0; payload = 0;
        quiet();
        #3;
        chk("rst_free", free_count, 8);
        chk("rst_dready", disp_ready, 1);
        chk("rst_ivalid", issue_valid, 0);
        chk("rst_rs1", iss_rs1, 0);
        chk("rst_dest", iss_dest, 0);
        step(); step();
        rst_n = 1'b1;
        step();

        // ready dispatch
        disp(1, 0, 5, 1, 0, 5, 3);
        step(); quiet();
        chk("rd_valid", issue_valid, 1);
        chk("rd_rs1", iss_rs1, 5);
        chk("rd_rs2", iss_rs2, 5);
        chk("rd_dest", iss_dest, 3);
        chk("rd_payload", iss_payload, 64'hC0DE_0000_0000_0003);
        chk("rd_free", free_count, 7);
        issue_ready = 1'b1; step(); issue_ready = 1'b0;
        chk("rd_free_after", free_count, 8);
        chk("rd_valid_after", issue_valid, 0);

        // CDB wakeup
        disp(0, 2, 0, 0, 4, 0, 6);
        step(); quiet();
        chk("wk_valid0", issue_valid, 0);
        cdb(1, 4, 10);
        step(); quiet();
        chk("wk_valid1", issue_valid, 0);
        cdb(0, 2, 7);
        #1 chk("wk_no_comb", issue_valid, 0);
        step(); quiet();
        chk("wk_valid2", issue_valid, 1);
        chk("wk_rs1", iss_rs1, 7);
        chk("wk_rs2", iss_rs2, 10);
        chk("wk_dest", iss_dest, 6);
        issue_ready = 1'b1; step(); issue_ready = 1'b0;
        chk("wk_free", free_count, 8);

        // same-cycle capture, lowest port wins, ready operand not overwritten
        disp(0, 3, 0, 1, 3, 20, 7);
        cdb(0, 3, 13);
        cdb(1, 3, 99);
        step(); quiet();
        chk("sc_valid", issue_valid, 1);
        chk("sc_rs1", iss_rs1, 13);
        chk("sc_rs2", iss_rs2, 20);
        issue_ready = 1'b1; step(); issue_ready = 1'b0;

        // tag 0 never captured
        disp(0, 0, 0, 1, 0, 8, 8);
        cdb(0, 0, 55);
        step(); quiet();
        cdb(1, 0, 56);
        step(); quiet();
        chk("t0_valid", issue_valid, 0);
        chk("t0_free", free_count, 7);
        flush = 1'b1; step(); flush = 1'b0;
        chk("t0_flush_free", free_count, 8);

        // oldest first with stall
        disp(1, 0, 11, 1, 0, 21, 1); step();
        disp(1, 0, 12, 1, 0, 22, 2); step();
        disp(1, 0, 13, 1, 0, 23, 3); step(); quiet();
        chk("of_dest_a", iss_dest, 1);
        step();
        chk("of_stall1", iss_dest, 1);
        step();
        chk("of_stall2", iss_dest, 1);
        chk("of_stall_rs1", iss_rs1, 11);
        issue_ready = 1'b1; step();
        chk("of_dest_b", iss_dest, 2);
        step();
        chk("of_dest_c", iss_dest, 3);
        step(); issue_ready = 1'b0;
        chk("of_empty", issue_valid, 0);

        // age beats index: reused low slot is younger; late wakeup of the oldest
        disp(0, 9, 0, 1, 0, 44, 4); step();
        disp(1, 0, 15, 1, 0, 25, 5); step();
        disp(1, 0, 16, 1, 0, 26, 6); issue_ready = 1'b1; step(); issue_ready = 1'b0;
        chk("ag_dest_f", iss_dest, 6);
        chk("ag_free1", free_count, 6);
        disp(1, 0, 17, 1, 0, 27, 7); step(); quiet();
        chk("ag_f_before_g", iss_dest, 6);
        chk("ag_free2", free_count, 5);
        cdb(0, 9, 99);
        step(); quiet();
        chk("ag_dest_d", iss_dest, 4);
        chk("ag_rs1_d", iss_rs1, 99);
        chk("ag_rs2_d", iss_rs2, 44);
        issue_ready = 1'b1; step();
        chk("ag_dest_f2", iss_dest, 6);
        step();
        chk("ag_dest_g", iss_dest, 7);
        step(); issue_ready = 1'b0;
        chk("ag_empty", issue_valid, 0);
        chk("ag_free3", free_count, 8);

        // full bank
        for (int i = 0; i < 8; i++) begin
            disp(1, 0, 32'(100 + i), 1, 0, 32'(200 + i), 5'(10 + i));
            step();
        end
        quiet();
        chk("fb_dready", disp_ready, 0);
        chk("fb_free", free_count, 0);
        chk("fb_dest", iss_dest, 10);
        disp(1, 0, 120, 1, 0, 220, 20);
        issue_ready = 1'b1; step(); issue_ready = 1'b0;
        chk("fb_held_free", free_count, 1);
        chk("fb_held_dready", disp_ready, 1);
        step(); quiet();
        chk("fb_accept_free", free_count, 0);
        chk("fb_accept_dready", disp_ready, 0);
        for (int i = 0; i < 7; i++) drain_exp[i] = 5'(11 + i);
        drain_exp[7] = 5'd20;
        issue_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("fb_drain%0d_valid", i), issue_valid, 1);
            chk($sformatf("fb_drain%0d_dest", i), iss_dest, drain_exp[i]);
            step();
        end
        issue_ready = 1'b0;
        chk("fb_drained", issue_valid, 0);
        chk("fb_drained_free", free_count, 8);

        // flush with 5 busy
        for (int i = 0; i < 5; i++) begin
            disp(1, 0, 32'(i), 1, 0, 32'(i), 5'(1 + i));
            step();
        end
        chk("fl_free_pre", free_count, 3);
        disp(1, 0, 1, 1, 0, 1, 30);
        issue_ready = 1'b1;
        flush = 1'b1;
        #1 chk("fl_ivalid_comb", issue_valid, 0);
        step();
        flush = 1'b0; issue_ready = 1'b0; quiet();
        chk("fl_free", free_count, 8);
        chk("fl_ivalid", issue_valid, 0);

        // reset mid-traffic
        for (int i = 0; i < 3; i++) begin
            disp(1, 0, 32'(50 + i), 1, 0, 32'(60 + i), 5'(20 + i));
            step();
        end
        chk("mr_free_pre", free_count, 5);
        chk("mr_ivalid_pre", issue_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mr_free", free_count, 8);
        chk("mr_dready", disp_ready, 1);
        chk("mr_ivalid", issue_valid, 0);
        chk("mr_rs1", iss_rs1, 0);
        chk("mr_dest", iss_dest, 0);
        step(); quiet();
        rst_n = 1'b1;
        step();
        chk("mr_free_post", free_count, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rs_bank.md
# rs_bank

Multi-entry reservation station for the P6 out-of-order core. It sits between dispatch (decode, map table and ROB operand lookup) and the functional units. It is the parametrised successor to the single-slot RS entry. It holds NUM_ENTRIES waiting instructions, snoops CDB_PORTS result broadcasts for operand wakeup, and issues the oldest fully-ready entry through a valid/ready handshake.

## Interface
- NUM_ENTRIES, 8: entry count; power of two, minimum 2.
- CDB_PORTS, 2: number of parallel CDB broadcast ports.
- TAG_W, 5: ROB tag width. Tag 0 is reserved for "value from register file" and never matches a CDB broadcast.
- XLEN, 32: operand width.
- PAYLOAD_W, 64: opaque decoded-control width (PC, NPC, alu_func, opa/opb select, mem/branch/halt flags). Stored and forwarded unmodified.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; 0 clears all state.
- flush  in  1  squash: empties the bank on the next edge.
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  at least one free entry.
- disp_rs1_ready, disp_rs2_ready  in  1 each  operand value already valid.
- disp_rs1_tag, disp_rs2_tag  in  TAG_W each  producer ROB tag when not ready.
- disp_rs1_value, disp_rs2_value  in  XLEN each  operand value when ready.
- disp_dest_tag  in  TAG_W  ROB entry of the instruction.
- disp_payload  in  PAYLOAD_W  decoded control.
- cdb_valid  in  CDB_PORTS  per-port broadcast valid.
- cdb_tag  in  CDB_PORTS*TAG_W  per-port tag, port k at bits [k*TAG_W +: TAG_W].
- cdb_value  in  CDB_PORTS*XLEN  per-port result.
- issue_valid  out  1  an issue candidate is presented.
- issue_ready  in  1  functional unit accepts.
- issue_rs1_value, issue_rs2_value  out  XLEN each  operands.
- issue_dest_tag  out  TAG_W  destination tag.
- issue_payload  out  PAYLOAD_W  control.
- free_count  out  $clog2(NUM_ENTRIES)+1  number of free entries.

## Operation
- Each entry holds: busy, rs1/rs2 ready flag, tag and value, dest_tag, payload, plus one row of an age matrix.
- **Dispatch:** when disp_valid && disp_ready && !flush, the lowest-index free entry is written and marked busy. Its age row marks it younger than every currently busy entry.
- **Same-cycle wakeup on dispatch:** if a not-ready operand's tag is non-zero and equals a valid cdb_tag in the same cycle, the entry stores cdb_value and marks that operand ready.
- **Wakeup:** every cycle, each busy entry compares each not-ready operand's non-zero tag against all valid CDB ports. On a match it captures the value and sets the ready flag.
  - If several ports match, the lowest port index wins.
  - Operands that are already ready are never overwritten.
- **Select:** candidate set = busy entries with both ready flags set (registered state). The oldest candidate per the age matrix is driven on the issue_* outputs. issue_valid = candidate set non-empty && !flush.
- **Issue:** on issue_valid && issue_ready, the selected entry's busy flag clears at the edge.
  - If issue_ready is low, outputs hold and the selection stays stable unless an older entry becomes ready.
- **Same-cycle dispatch and issue:** disp_ready reflects the current occupancy (a slot freed this cycle is not counted). Both operations complete at the same edge.
- **free_count** = NUM_ENTRIES minus the number of busy entries, updated at each edge.
- **Flush:** all busy flags clear at the next edge. Dispatch and issue are suppressed in the flush cycle.
- A full bank with disp_valid high is not an error: no write occurs, and the requester must hold.

## Timing
- **Reset values:** busy=0 for all entries, disp_ready=1, issue_valid=0, free_count=NUM_ENTRIES. issue_* data outputs are 0.
- **Dispatch to issue:** an entry dispatched at edge t with both operands ready (or woken by the CDB in the dispatch cycle) has issue_valid in the cycle after t. Latency is 1 cycle.
- **CDB to issue:** a broadcast in cycle c makes the entry eligible in cycle c+1. There is no combinational CDB-to-issue path.
- **Combinational outputs:** issue_valid, the issue data and disp_ready are combinational from registered state plus flush. No output depends combinationally on issue_ready or disp_valid.
- **Reset mid-operation:** the asynchronous clear takes effect immediately; outputs take their reset values while reset is 0.

## Test plan
- **Ready dispatch:** dispatch rs1=rs2 ready with values 5/5, dest 3 → next cycle issue_valid=1, values 5/5, dest 3, free_count=7; issue_ready=1 → free_count returns to 8.
- **CDB wakeup:** dispatch with rs1_tag=2 and rs2_tag=4 not ready → issue_valid=0.
  - Broadcast tag 4 value 10 on port 1 → still 0.
  - Broadcast tag 2 value 7 on port 0 → next cycle issue_valid=1 with values 7/10.
- **Same-cycle capture:** dispatch rs1_tag=3 not ready while cdb port 0 carries tag 3 value 13 → next cycle rs1=13 and ready. Tag-0 operands are never captured from a CDB port carrying tag 0.
- **Oldest first:** dispatch A, B, C, all ready with dest tags 1, 2, 3; hold issue_ready=0 for 2 cycles, then 1 → issue order 1, 2, 3, with outputs stable while stalled.
- **Full bank:** fill 8 entries → disp_ready=0, free_count=0. Issue one and dispatch in the same cycle → the dispatch is held. The next cycle it is accepted into the freed (lowest-index) slot.
- **Flush and reset:** flush with 5 busy entries → next cycle free_count=8, issue_valid=0. Drop reset mid-traffic → outputs take reset values immediately.
